vxv_vector_buffer: RTL

VXV_VECTOR_BUFFER -- requirements
Module: vxv_vector_buffer

---
 rtl/vxv_vector_buffer_pkg.sv | 39 +++
 rtl/vxv_vector_buffer_if.sv | 48 ++++
 rtl/vxv_vector_buffer_beat_mux.sv | 33 +++
 rtl/vxv_vector_buffer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/vxv_vector_buffer_pkg.sv
// ---------------------------------------------------------------------------
// vxv_vector_buffer_pkg
// Shared definitions for the vector buffer: the stream FSM state encoding and
// the helper functions that turn (N, U, D) into padding, padded vector length,
// beat count and index widths. All functions are constant-evaluable so they
// can size ports and localparams.
// ---------------------------------------------------------------------------
package vxv_vector_buffer_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Zero elements appended so the vector fills a whole number of beats.
  function automatic int calc_pad(input int n, input int u);
    return (u - (n % u)) % u;
  endfunction

  function automatic int calc_total(input int n, input int u);
    return n + calc_pad(n, u);
  endfunction

  function automatic int calc_beats(input int n, input int u);
    return calc_total(n, u) / u;
  endfunction

  // Beat index width, never narrower than one bit.
  function automatic int calc_beat_w(input int n, input int u);
    int b;
    b = calc_beats(n, u);
    return (b <= 1) ? 1 : $clog2(b);
  endfunction

  function automatic int calc_slot_w(input int d);
    return (d <= 1) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/vxv_vector_buffer_if.sv
// ---------------------------------------------------------------------------
// vxv_vector_buffer_if
// Bundles the write port, read-start port and beat stream of the vector
// buffer.
//   master : the client (writes vectors, starts streams, consumes beats)
//   slave  : the buffer itself
// Write : wr_en, wr_slot, input_data -> wr_err
// Read  : rd_start, rd_slot          -> rd_busy, rd_err
// Beats : out_valid, out_data, out_last <- out_ready
// Misc  : clear -> slot_valid
// ---------------------------------------------------------------------------
interface vxv_vector_buffer_if
  import vxv_vector_buffer_pkg::*;
#(
  parameter int element_width                   = 32,
  parameter int number_of_equations_per_cluster = 9,
  parameter int no_of_units                     = 8,
  parameter int depth                           = 4
) ();

  localparam int slot_w = calc_slot_w(depth);

  logic                                                  wr_en;
  logic [slot_w-1:0]                                     wr_slot;
  logic [element_width*number_of_equations_per_cluster-1:0] input_data;
  logic                                                  wr_err;
  logic                                                  rd_start;
  logic [slot_w-1:0]                                     rd_slot;
  logic                                                  rd_busy;
  logic                                                  out_valid;
  logic                                                  out_ready;
  logic [element_width*no_of_units-1:0]                  out_data;
  logic                                                  out_last;
  logic                                                  rd_err;
  logic [depth-1:0]                                      slot_valid;
  logic                                                  clear;

  modport master (
    output wr_en, wr_slot, input_data, rd_start, rd_slot, out_ready, clear,
    input  wr_err, rd_busy, out_valid, out_data, out_last, rd_err, slot_valid
  );

  modport slave (
    input  wr_en, wr_slot, input_data, rd_start, rd_slot, out_ready, clear,
    output wr_err, rd_busy, out_valid, out_data, out_last, rd_err, slot_valid
  );

endinterface

// File: rtl/vxv_vector_buffer_beat_mux.sv
// ---------------------------------------------------------------------------
// vxv_beat_mux
// Selects one U-element beat out of a padded vector image. Beat 0 is the
// most-significant slice, so elements leave in the same order they sit in
// the written vector. An out-of-range index yields zero.
//   image    in  full padded vector (beats * U elements)
//   beat_idx in  beat to select
//   beat     out selected U-element slice
// ---------------------------------------------------------------------------
module vxv_beat_mux #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int beats         = 2,
  parameter int beat_w        = 1
) (
  input  logic [element_width*no_of_units*beats-1:0] image,
  input  logic [beat_w-1:0]                          beat_idx,
  output logic [element_width*no_of_units-1:0]       beat
);

  localparam int beat_dw = element_width * no_of_units;
  localparam int img_w   = beat_dw * beats;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise an unmatched index would infer a latch.
  always_comb begin
    beat = '0;
    for (int k = 0; k < beats; k++) begin
      if (beat_idx == beat_w'(k)) beat = image[img_w-1-k*beat_dw -: beat_dw];
    end
  end

endmodule

// File: rtl/vxv_vector_buffer.sv
// ---------------------------------------------------------------------------
// vxv_vector_buffer
// Holds `depth` vectors of N elements, each zero-padded at the LSB end to a
// whole number of U-element beats, and streams a chosen slot out as a
// valid/ready beat sequence (most-significant elements first).
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  write port, read-start port, beat stream, clear, slot_valid
// A write to the slot currently streaming is rejected (wr_err). A start on an
// unwritten slot is rejected (rd_err). The image is snapshotted when a stream
// starts, so a write accepted in that same cycle never leaks into the stream.
// ---------------------------------------------------------------------------
module vxv_vector_buffer
  import vxv_vector_buffer_pkg::*;
#(
  parameter int element_width                   = 32,
  parameter int number_of_equations_per_cluster = 9,
  parameter int no_of_units                     = 8,
  parameter int depth                           = 4
) (
  input logic              clk,
  input logic              rst_n,
  vxv_vector_buffer_if.slave bus
);

  localparam int n       = number_of_equations_per_cluster;
  localparam int pad     = calc_pad(n, no_of_units);
  localparam int total   = calc_total(n, no_of_units);
  localparam int beats   = calc_beats(n, no_of_units);
  localparam int slot_w  = calc_slot_w(depth);
  localparam int beat_w  = calc_beat_w(n, no_of_units);
  localparam int img_w   = element_width * total;
  localparam int beat_dw = element_width * no_of_units;
  localparam int pad_w   = element_width * pad;

  localparam logic [beat_w-1:0] last_beat = beat_w'(beats - 1);
  localparam logic [beat_w-1:0] beat_one  = beat_w'(1);

  logic [img_w-1:0]   mem [depth];

  state_e             state;
  logic [beat_w-1:0]  beat_idx;
  logic [slot_w-1:0]  active_slot;
  logic [img_w-1:0]   img;
  logic [depth-1:0]   slot_valid;
  logic               out_valid;
  logic [beat_dw-1:0] out_data;
  logic               out_last;
  logic               wr_err;
  logic               rd_err;

  logic [img_w-1:0]   wr_image;
  logic               wr_block;
  logic               wr_ok;
  logic               rd_ok;
  logic [img_w-1:0]   mux_src;
  logic [beat_w-1:0]  mux_idx;
  logic [beat_dw-1:0] mux_beat;

  // Pad zeros land in the least-significant element positions.
  assign wr_image = img_w'(bus.input_data) << pad_w;

  assign wr_block = (state == ST_STREAM) && (bus.wr_slot == active_slot);
  assign wr_ok    = bus.wr_en && !wr_block;
  assign rd_ok    = bus.rd_start && (state == ST_IDLE) && slot_valid[bus.rd_slot];

  // In IDLE the mux previews beat 0 of the slot being started (pre-write
  // contents, since storage only changes at the edge); while streaming it
  // looks one beat ahead in the snapshot.
  always_comb begin
    mux_src = mem[bus.rd_slot];
    mux_idx = '0;
    if (state == ST_STREAM) begin
      mux_src = img;
      mux_idx = beat_idx + beat_one;
    end
  end

  vxv_beat_mux #(
    .element_width(element_width),
    .no_of_units  (no_of_units),
    .beats        (beats),
    .beat_w       (beat_w)
  ) u_beat_mux (
    .image   (mux_src),
    .beat_idx(mux_idx),
    .beat    (mux_beat)
  );

  // NOTE: vector storage carries no reset; its contents are meaningless until
  // slot_valid says otherwise, and a reset here would add nothing but wiring.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[bus.wr_slot] <= wr_image;
  end

  // NOTE: all state in clocked blocks uses non-blocking assignments so every
  // right-hand side sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      beat_idx    <= '0;
      active_slot <= '0;
      img         <= '0;
      slot_valid  <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      wr_err      <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      wr_err <= bus.wr_en && wr_block;
      rd_err <= bus.rd_start && (state == ST_IDLE) && !slot_valid[bus.rd_slot];

      // A write in the same cycle as clear re-validates its own slot.
      if (bus.clear) slot_valid <= '0;
      if (wr_ok)     slot_valid[bus.wr_slot] <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (rd_ok) begin
            state       <= ST_STREAM;
            img         <= mem[bus.rd_slot];
            active_slot <= bus.rd_slot;
            beat_idx    <= '0;
            out_valid   <= 1'b1;
            out_data    <= mux_beat;
            out_last    <= (beats == 1);
          end
        end
        ST_STREAM: begin
          if (out_valid && bus.out_ready) begin
            if (beat_idx == last_beat) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
            end else begin
              beat_idx <= mux_idx;
              out_data <= mux_beat;
              out_last <= (mux_idx == last_beat);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_busy    = (state == ST_STREAM);
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.out_last   = out_last;
  assign bus.wr_err     = wr_err;
  assign bus.rd_err     = rd_err;
  assign bus.slot_valid = slot_valid;

endmodule
